rocc_frontend: RTL

- Parametrised successor RoCC command front end for the warp accelerator; core-agnostic.
- Adds an XLEN-wide datapath and a command FIFO of configurable depth, so the core can queue commands while a kernel runs.
- Honours the RoCC xd bit (response only when requested) and adds asynchronous kernel launch with completion interrupt and sticky error reporting.
- Sits between the core's RoCC port and the warp controller / mask unit.

---
 rtl/warp_pkg.sv | 36 +++
 rtl/rocc_frontend_if.sv | 47 ++++
 rtl/rocc_cmd_fifo.sv | 57 +++++
 rtl/rocc_frontend.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/warp_pkg.sv
// Shared types and constants for the warp accelerator RoCC front end.
package warp_pkg;

    localparam int NUM_LANES_DEFAULT = 8;
    localparam int ADDR_WIDTH        = 32;
    localparam int XLEN_MAX          = 64;

    typedef enum logic [6:0] {
        KERNEL_START  = 7'd0,
        SET_MASK      = 7'd1,
        GET_STATUS    = 7'd2,
        KERNEL_LAUNCH = 7'd3,
        GET_PERF      = 7'd4
    } rocc_opcode_e;

    typedef logic [5:0] warp_status_t;

    // Operands are stored at the widest XLEN and truncated on use.
    typedef struct packed {
        logic [6:0]          funct;
        logic [4:0]          rd;
        logic                xd;
        logic [XLEN_MAX-1:0] rs1;
        logic [XLEN_MAX-1:0] rs2;
    } rocc_cmd_t;

    localparam logic [XLEN_MAX-1:0] ROCC_RESP_ILLEGAL = {XLEN_MAX{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WAIT_DONE,
        ST_RESP
    } fe_state_e;

endpackage

// File: rtl/rocc_frontend_if.sv
// RoCC command/response, kernel control and mask bus between core, front end and warp.
interface rocc_frontend_if #(
    parameter int NUM_LANES  = warp_pkg::NUM_LANES_DEFAULT,
    parameter int ADDR_WIDTH = warp_pkg::ADDR_WIDTH,
    parameter int XLEN       = 32,
    parameter int CMD_DEPTH  = 4
);
    import warp_pkg::*;

    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [6:0]                   cmd_funct;
    logic [4:0]                   cmd_rd;
    logic                         cmd_xd;
    logic [XLEN-1:0]              cmd_rs1_data;
    logic [XLEN-1:0]              cmd_rs2_data;
    logic                         resp_valid;
    logic                         resp_ready;
    logic [4:0]                   resp_rd;
    logic [XLEN-1:0]              resp_data;
    logic                         busy;
    logic                         interrupt;
    logic                         kernel_start;
    logic [ADDR_WIDTH-1:0]        kernel_addr;
    logic [15:0]                  kernel_length;
    logic                         kernel_done;
    logic                         kernel_error;
    logic                         mask_update;
    logic [NUM_LANES-1:0]         mask_value;
    warp_status_t                 status;
    logic [$clog2(CMD_DEPTH):0]   cmd_count;

    modport slave (
        input  cmd_valid, cmd_funct, cmd_rd, cmd_xd, cmd_rs1_data, cmd_rs2_data,
        input  resp_ready, kernel_done, kernel_error, status,
        output cmd_ready, resp_valid, resp_rd, resp_data, busy, interrupt,
        output kernel_start, kernel_addr, kernel_length, mask_update, mask_value, cmd_count
    );

    modport master (
        output cmd_valid, cmd_funct, cmd_rd, cmd_xd, cmd_rs1_data, cmd_rs2_data,
        output resp_ready, kernel_done, kernel_error, status,
        input  cmd_ready, resp_valid, resp_rd, resp_data, busy, interrupt,
        input  kernel_start, kernel_addr, kernel_length, mask_update, mask_value, cmd_count
    );

endinterface

// File: rtl/rocc_cmd_fifo.sv
// Synchronous command FIFO of rocc_cmd_t with occupancy count; DEPTH must be a power of two.
module rocc_cmd_fifo
    import warp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  rocc_cmd_t                push_data_i,
    input  logic                     pop_i,
    output rocc_cmd_t                head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rocc_cmd_t              mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic                   do_push;
    logic                   do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem[rd_ptr_q];
    assign count_o = count_q;

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rocc_frontend.sv
// RoCC command front end: queues core commands and dispatches them to the warp controller.
// Optional cycle counter and GET_PERF opcode enabled by ROCC_PERF_CNT_EN.
module rocc_frontend #(
    parameter int NUM_LANES  = warp_pkg::NUM_LANES_DEFAULT,
    parameter int ADDR_WIDTH = warp_pkg::ADDR_WIDTH,
    parameter int XLEN       = 32,
    parameter int CMD_DEPTH  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    rocc_frontend_if.slave bus
);
    import warp_pkg::*;

    rocc_cmd_t                   push_cmd;
    rocc_cmd_t                   head_cmd;
    rocc_cmd_t                   cmd_q;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_pop;
    logic [$clog2(CMD_DEPTH):0]  fifo_count;
    logic                        head_is_kernel;

    fe_state_e                   state_q;
    logic                        kernel_active_q;
    logic                        async_q;
    logic                        err_sticky_q;
    logic                        interrupt_q;
    logic                        resp_valid_q;
    logic [4:0]                  resp_rd_q;
    logic [XLEN-1:0]             resp_data_q;
    logic                        kernel_start_q;
    logic [ADDR_WIDTH-1:0]       kernel_addr_q;
    logic [15:0]                 kernel_length_q;
    logic                        mask_update_q;
    logic [NUM_LANES-1:0]        mask_value_q;
    logic                        kernel_event;
    logic                        unused_bits;

    always_comb begin
        push_cmd       = '0;
        push_cmd.funct = bus.cmd_funct;
        push_cmd.rd    = bus.cmd_rd;
        push_cmd.xd    = bus.cmd_xd;
        push_cmd.rs1   = XLEN_MAX'(bus.cmd_rs1_data);
        push_cmd.rs2   = XLEN_MAX'(bus.cmd_rs2_data);
    end

    rocc_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (bus.cmd_valid && !fifo_full),
        .push_data_i (push_cmd),
        .pop_i       (fifo_pop),
        .head_o      (head_cmd),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // A kernel command waits at the head until the running kernel retires.
    assign head_is_kernel = (head_cmd.funct == KERNEL_START) || (head_cmd.funct == KERNEL_LAUNCH);
    assign fifo_pop       = (state_q == ST_IDLE) && !fifo_empty && !(head_is_kernel && kernel_active_q);
    assign kernel_event   = bus.kernel_done || bus.kernel_error;
    assign unused_bits    = ^{cmd_q.rs1, cmd_q.rs2};

`ifdef ROCC_PERF_CNT_EN
    logic [31:0] perf_cnt_q;
    logic        perf_clear;

    assign perf_clear = (state_q == ST_EXEC) &&
                        ((cmd_q.funct == KERNEL_START) || (cmd_q.funct == KERNEL_LAUNCH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_q <= '0;
        end else if (perf_clear) begin
            perf_cnt_q <= '0;
        end else if (kernel_active_q && (perf_cnt_q != '1)) begin
            perf_cnt_q <= perf_cnt_q + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cmd_q           <= '0;
            kernel_active_q <= 1'b0;
            async_q         <= 1'b0;
            err_sticky_q    <= 1'b0;
            interrupt_q     <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_rd_q       <= '0;
            resp_data_q     <= '0;
            kernel_start_q  <= 1'b0;
            kernel_addr_q   <= '0;
            kernel_length_q <= '0;
            mask_update_q   <= 1'b0;
            mask_value_q    <= '0;
        end else begin
            kernel_start_q <= 1'b0;
            mask_update_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        cmd_q   <= head_cmd;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    resp_rd_q    <= cmd_q.rd;
                    resp_data_q  <= '0;
                    resp_valid_q <= cmd_q.xd;
                    state_q      <= ST_RESP;
                    case (cmd_q.funct)
                        KERNEL_START, KERNEL_LAUNCH: begin
                            kernel_start_q  <= 1'b1;
                            kernel_addr_q   <= cmd_q.rs1[ADDR_WIDTH-1:0];
                            kernel_length_q <= cmd_q.rs2[15:0];
                            kernel_active_q <= 1'b1;
                            async_q         <= (cmd_q.funct == KERNEL_LAUNCH);
                            if (cmd_q.funct == KERNEL_START) begin
                                resp_valid_q <= 1'b0;
                                state_q      <= ST_WAIT_DONE;
                            end
                        end
                        SET_MASK: begin
                            mask_update_q <= 1'b1;
                            mask_value_q  <= cmd_q.rs1[NUM_LANES-1:0];
                        end
                        GET_STATUS: begin
                            resp_data_q  <= XLEN'({err_sticky_q, bus.status});
                            err_sticky_q <= 1'b0;
                            interrupt_q  <= 1'b0;
                        end
`ifdef ROCC_PERF_CNT_EN
                        GET_PERF: begin
                            resp_data_q <= XLEN'(perf_cnt_q);
                        end
`endif
                        default: begin
                            resp_data_q  <= ROCC_RESP_ILLEGAL[XLEN-1:0];
                            err_sticky_q <= 1'b1;
                        end
                    endcase
                end
                ST_WAIT_DONE: begin
                    if (kernel_event) begin
                        kernel_active_q <= 1'b0;
                        resp_data_q     <= XLEN'(bus.kernel_error);
                        resp_valid_q    <= cmd_q.xd;
                        state_q         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (!resp_valid_q || bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Placed after the dispatch case so an async set beats a GET_STATUS clear.
            if (kernel_active_q && async_q && kernel_event) begin
                kernel_active_q <= 1'b0;
                async_q         <= 1'b0;
                interrupt_q     <= 1'b1;
                if (bus.kernel_error) err_sticky_q <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready     = !fifo_full;
    assign bus.cmd_count     = fifo_count;
    assign bus.busy          = !fifo_empty || (state_q != ST_IDLE) || kernel_active_q;
    assign bus.interrupt     = interrupt_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rd       = resp_rd_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.kernel_start  = kernel_start_q;
    assign bus.kernel_addr   = kernel_addr_q;
    assign bus.kernel_length = kernel_length_q;
    assign bus.mask_update   = mask_update_q;
    assign bus.mask_value    = mask_value_q;

endmodule
